// File: rtl/steer_slew_if.sv
// Command/response bundle between the balance controller and the wheel-speed pipe.
interface steer_slew_if #(
   parameter int W = 12
);
   logic                pwr_up;
   logic                rider_off;
   logic                cmd_vld;
   logic signed [W-1:0] PID_cntrl;
   logic [11:0]         steer_pot;
   logic                en_steer;
   logic signed [W-1:0] lft_spd;
   logic signed [W-1:0] rght_spd;
   logic                spd_vld;
   logic                too_fast;
   logic                ss_done;

   modport master (
      output pwr_up, rider_off, cmd_vld, PID_cntrl, steer_pot, en_steer,
      input  lft_spd, rght_spd, spd_vld, too_fast, ss_done
   );
   modport slave (
      input  pwr_up, rider_off, cmd_vld, PID_cntrl, steer_pot, en_steer,
      output lft_spd, rght_spd, spd_vld, too_fast, ss_done
   );
endinterface

// File: rtl/steer_slew_pipe.sv
// Balance command to wheel speeds: soft-start scaling and steering mix in stage 1,
// per-wheel slew limiting plus overspeed hysteresis in stage 2.

module steer_slew_lane #(
   parameter int W    = 12,
   parameter int SLEW = 64,
   parameter bit NEG  = 1'b0
) (
   input  logic signed [W-1:0] scaled,
   input  logic signed [W:0]   steer_term,
   input  logic                en_steer,
   input  logic                rider_off,
   input  logic signed [W-1:0] cur,
   output logic signed [W-1:0] nxt,
   output logic        [W:0]   mag
);
   localparam logic signed [W:0] MAX_S  = (W+1)'((1 << (W-1)) - 1);
   localparam logic signed [W:0] MIN_S  = (W+1)'(-(1 << (W-1)));
   localparam logic signed [W:0] SLEW_S = (W+1)'(SLEW);

   logic signed [W:0]   base, sum, diff, ext;
   logic signed [W-1:0] tgt;

   always_comb begin
      base = {scaled[W-1], scaled};
      if (!en_steer)  sum = base;
      else if (NEG)   sum = base - steer_term;
      else            sum = base + steer_term;

      if (rider_off)        tgt = '0;
      else if (sum > MAX_S) tgt = MAX_S[W-1:0];
      else if (sum < MIN_S) tgt = MIN_S[W-1:0];
      else                  tgt = sum[W-1:0];

      // step toward the target, landing on it once within one slew step
      diff = {tgt[W-1], tgt} - {cur[W-1], cur};
      if (diff > SLEW_S)       nxt = cur + SLEW_S[W-1:0];
      else if (diff < -SLEW_S) nxt = cur - SLEW_S[W-1:0];
      else                     nxt = tgt;

      // one extra bit so the most negative speed reports its true magnitude
      ext = {nxt[W-1], nxt};
      mag = ext[W] ? -ext : ext;
   end
endmodule

module steer_slew_pipe #(
   parameter int W        = 12,
   parameter int SLEW     = 64,
   parameter int FAST_THR = 1536,
   parameter int FAST_HYS = 128
) (
   input logic         clk,
   input logic         rst_n,
   steer_slew_if.slave bus
);
   localparam int NUM_LANES = 2;
   localparam int STAGES    = 1;
   localparam logic [W:0] THR_HI = (W+1)'(FAST_THR);
   localparam logic [W:0] THR_LO = (W+1)'(FAST_THR - FAST_HYS);

   typedef struct packed {
      logic [W-1:0] pid;
      logic [7:0]   ss;
      logic [11:0]  pot;
      logic         en_steer;
   } s1_t;

   s1_t                         s1;
   logic [7:0]                  ss_tmr;
   logic [STAGES:0]             vld_pipe;
   logic [NUM_LANES-1:0][W-1:0] spd, spd_nxt;
   logic [NUM_LANES-1:0][W:0]   mag;
   logic                        too_fast;
   logic                        any_hi, all_lo;

   logic [11:0]         pot_c;
   logic signed [12:0]  s;
   logic signed [14:0]  s3;
   logic signed [W:0]   steer_term;
   logic signed [W+8:0] prod;
   logic signed [W-1:0] scaled;

   // soft-start scaling uses the timer value captured with the command
   always_comb begin
      pot_c      = (s1.pot < 12'h200) ? 12'h200 : (s1.pot > 12'hE00) ? 12'hE00 : s1.pot;
      s          = $signed({1'b0, pot_c}) - 13'sd2047;
      s3         = 15'(s) * 15'sd3;
      steer_term = (W+1)'(s3 >>> 4);
      prod       = (W+9)'($signed(s1.pid)) * (W+9)'($signed({1'b0, s1.ss}));
      scaled     = W'(prod >>> 8);
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      steer_slew_lane #(.W(W), .SLEW(SLEW), .NEG(i != 0)) u_lane (
         .scaled     (scaled),
         .steer_term (steer_term),
         .en_steer   (s1.en_steer),
         .rider_off  (bus.rider_off),
         .cur        (spd[i]),
         .nxt        (spd_nxt[i]),
         .mag        (mag[i])
      );
   end

   always_comb begin
      any_hi = 1'b0;
      all_lo = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (mag[i] > THR_HI)   any_hi = 1'b1;
         if (!(mag[i] < THR_LO)) all_lo = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_tmr   <= '0;
         s1       <= '0;
         vld_pipe <= '0;
         spd      <= '0;
         too_fast <= 1'b0;
      end else if (!bus.pwr_up) begin
         ss_tmr   <= '0;
         vld_pipe <= '0;
         spd      <= '0;
         too_fast <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], bus.cmd_vld};
         if (bus.cmd_vld) begin
            s1 <= '{pid: bus.PID_cntrl, ss: ss_tmr, pot: bus.steer_pot, en_steer: bus.en_steer};
            if (ss_tmr != 8'hFF) ss_tmr <= ss_tmr + 8'd1;
         end
         if (vld_pipe[0]) begin
            spd <= spd_nxt;
            if (any_hi)      too_fast <= 1'b1;
            else if (all_lo) too_fast <= 1'b0;
         end
      end
   end

   assign bus.lft_spd  = spd[0];
   assign bus.rght_spd = spd[1];
   assign bus.spd_vld  = vld_pipe[STAGES];
   assign bus.too_fast = too_fast;
   assign bus.ss_done  = (ss_tmr == 8'hFF);
endmodule

// File: tb/tb_steer_slew_pipe.sv
// Directed bench for steer_slew_pipe: soft-start, slew ramps, steering saturation,
// overspeed hysteresis, power drop, rider-off, back-to-back strobes and mid-flight reset.
module tb_steer_slew_pipe;
   localparam int W = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   steer_slew_if #(.W(W)) bus ();

   steer_slew_pipe #(.W(W), .SLEW(64), .FAST_THR(1536), .FAST_HYS(128)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int el, input int er, input int etf);
      chk({tag, "_l"},  32'($signed(bus.lft_spd)),  el);
      chk({tag, "_r"},  32'($signed(bus.rght_spd)), er);
      chk({tag, "_tf"}, 32'(bus.too_fast),          etf);
   endtask

   // single isolated strobe: no spd_vld at n+1, update visible at n+2
   task automatic one(input string tag, input int pid, input int el, input int er, input int etf);
      bus.PID_cntrl = W'(pid);
      bus.cmd_vld   = 1'b1;
      step();
      bus.cmd_vld = 1'b0;
      chk({tag, "_vld_n1"}, 32'(bus.spd_vld), 0);
      step();
      chk({tag, "_vld_n2"}, 32'(bus.spd_vld), 1);
      chk_out(tag, el, er, etf);
      step();
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   initial begin
      bus.pwr_up    = 1'b0;
      bus.rider_off = 1'b0;
      bus.cmd_vld   = 1'b0;
      bus.PID_cntrl = '0;
      bus.steer_pot = 12'h7FF;
      bus.en_steer  = 1'b0;
      repeat (3) step();

      chk_out("rst", 0, 0, 0);
      chk("rst_vld",  32'(bus.spd_vld), 0);
      chk("rst_done", 32'(bus.ss_done), 0);

      rst_n      = 1'b1;
      bus.pwr_up = 1'b1;

      // soft-start timer: 300 back-to-back strobes with zero command
      bus.cmd_vld = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k == 254) begin
            chk("ss_254_tmr",  32'(u_dut.ss_tmr), 254);
            chk("ss_254_done", 32'(bus.ss_done), 0);
         end
         if (k == 255) begin
            chk("ss_255_tmr",  32'(u_dut.ss_tmr), 255);
            chk("ss_255_done", 32'(bus.ss_done), 1);
         end
      end
      chk("ss_300_tmr", 32'(u_dut.ss_tmr), 255);
      bus.cmd_vld = 1'b0;
      repeat (3) step();
      chk("drain_vld", 32'(bus.spd_vld), 0);

      // 1000*255>>8 = 996, ramp by 64
      for (int k = 1; k <= 18; k++)
         one($sformatf("ramp996_%0d", k), 1000, imin(64*k, 996), imin(64*k, 996), 0);

      // 1800 -> 1792 target; too_fast once above 1536 (step 9: 1572)
      for (int k = 1; k <= 14; k++)
         one($sformatf("fast_up_%0d", k), 1800, imin(996 + 64*k, 1792), imin(996 + 64*k, 1792),
             (k >= 9) ? 1 : 0);
      // 1456 -> 1450 target, stays inside hysteresis band
      for (int k = 1; k <= 7; k++)
         one($sformatf("hys_hold_%0d", k), 1456, imax(1792 - 64*k, 1450), imax(1792 - 64*k, 1450), 1);
      // 1406 -> 1400 target, below 1408 clears the flag
      one("hys_clr", 1406, 1400, 1400, 0);

      // steering full right: scaled 1992, steer_term +288 -> lft sat 2047, rght 1704
      bus.en_steer  = 1'b1;
      bus.steer_pot = 12'hFFF;
      for (int k = 1; k <= 12; k++)
         one($sformatf("steer_%0d", k), 2000, imin(1400 + 64*k, 2047), imin(1400 + 64*k, 1704),
             (k >= 3) ? 1 : 0);
      // steering full left: steer_term -288, targets swap
      bus.steer_pot = 12'h000;
      one("steer_neg", 2000, 1983, 1768, 1);

      // in-flight strobe, then pwr_up low with an ignored strobe
      bus.PID_cntrl = 12'sd2000;
      bus.cmd_vld   = 1'b1;
      step();
      bus.pwr_up = 1'b0;
      step();
      bus.pwr_up  = 1'b1;
      bus.cmd_vld = 1'b0;
      chk_out("pwr_low", 0, 0, 0);
      chk("pwr_low_vld",  32'(bus.spd_vld), 0);
      chk("pwr_low_tmr",  32'(u_dut.ss_tmr), 0);
      chk("pwr_low_done", 32'(bus.ss_done), 0);
      step();
      chk("pwr_low_vld2", 32'(bus.spd_vld), 0);
      step();
      chk("pwr_low_vld3", 32'(bus.spd_vld), 0);

      // rebuild soft-start with zero command
      bus.en_steer  = 1'b0;
      bus.steer_pot = 12'h7FF;
      bus.PID_cntrl = '0;
      bus.cmd_vld   = 1'b1;
      repeat (255) step();
      bus.cmd_vld = 1'b0;
      repeat (3) step();
      chk("ss_rebuilt", 32'(bus.ss_done), 1);

      // 804*255>>8 = 800
      for (int k = 1; k <= 14; k++)
         one($sformatf("ramp800_%0d", k), 804, imin(64*k, 800), imin(64*k, 800), 0);
      bus.rider_off = 1'b1;
      for (int k = 1; k <= 14; k++)
         one($sformatf("rider_%0d", k), 804, imax(800 - 64*k, 0), imax(800 - 64*k, 0), 0);
      bus.rider_off = 1'b0;

      // five back-to-back strobes from zero
      bus.PID_cntrl = 12'sd804;
      for (int i = 0; i <= 7; i++) begin
         bus.cmd_vld = (i < 5);
         chk($sformatf("b2b_vld_%0d", i), 32'(bus.spd_vld), (i >= 2 && i <= 6) ? 1 : 0);
         if (i >= 2 && i <= 6)
            chk($sformatf("b2b_l_%0d", i), 32'($signed(bus.lft_spd)), 64*(i-1));
         step();
      end
      chk_out("b2b_end", 320, 320, 0);

      // reset while a strobe is in flight
      bus.cmd_vld = 1'b1;
      step();
      bus.cmd_vld = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk_out("mid_rst_async", 0, 0, 0);
      step();
      chk("mid_rst_vld", 32'(bus.spd_vld), 0);
      rst_n = 1'b1;
      step();
      chk("mid_rst_vld2", 32'(bus.spd_vld), 0);
      chk_out("mid_rst", 0, 0, 0);
      chk("mid_rst_tmr", 32'(u_dut.ss_tmr), 0);

      // first strobe after reset: ss_tmr 0 scales the command to zero
      one("post_rst", 804, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
